// File: rtl/ray_box_intersector.sv
// ray_box_intersector
// Slab test of one primary ray against one axis-aligned box. Processes one ray
// at a time: for each axis the entry and exit distances are computed with a
// single shared restoring divider, then merged into a running [t_near, t_far]
// interval. The final interval decides hit/miss for the shading stage.
module ray_box_intersector #(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_dir_x,
    input  logic [31:0] in_dir_y,
    input  logic [31:0] in_dir_z,
    input  logic [10:0] in_org_x,
    input  logic [10:0] in_org_y,
    input  logic [10:0] in_org_z,
    input  logic [31:0] in_loop_index,
    input  logic [10:0] box_min_x,
    input  logic [10:0] box_min_y,
    input  logic [10:0] box_min_z,
    input  logic [10:0] box_max_x,
    input  logic [10:0] box_max_y,
    input  logic [10:0] box_max_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hit,
    output logic [31:0] out_t_near,
    output logic [31:0] out_t_far,
    output logic [31:0] out_loop_index
);

    // Dividend width; also the number of cycles one division takes.
    localparam int NUM_W = 12 + FRAC_BITS;
    localparam int CNT_W = $clog2(NUM_W);
    localparam int REM_W = 34;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_DIV_LO = 3'd2;
    localparam logic [2:0] S_DIV_HI = 3'd3;
    localparam logic [2:0] S_MERGE  = 3'd4;
    localparam logic [2:0] S_FINAL  = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    localparam logic signed [31:0] T_NEG = 32'sh8000_0000;
    localparam logic signed [31:0] T_POS = 32'sh7FFF_FFFF;

    logic [2:0]  state;
    logic [1:0]  axis;
    logic        in_ready_q;
    logic        out_valid_q;

    // Ray and box captured at accept.
    logic [31:0] dir_q  [3];
    logic [10:0] org_q  [3];
    logic [10:0] bmin_q [3];
    logic [10:0] bmax_q [3];
    logic [31:0] idx_q;

    // Running interval and the current axis' slab distances.
    logic signed [31:0] t_near;
    logic signed [31:0] t_far;
    logic signed [31:0] t0;
    logic signed [31:0] t1;
    logic               miss;

    // Restoring divider state.
    logic [NUM_W-1:0] dvd_sh;
    logic [REM_W-1:0] rem;
    logic [NUM_W-1:0] quo;
    logic [CNT_W-1:0] cnt;

    // Current-axis operands and divider next-step values.
    logic [31:0]        cur_dir;
    logic [10:0]        cur_org;
    logic [10:0]        cur_min;
    logic [10:0]        cur_max;
    logic [11:0]        cur_lo;
    logic [11:0]        cur_hi;
    logic [11:0]        lo_mag;
    logic [11:0]        hi_mag;
    logic               dir_neg;
    logic [32:0]        dir_mag;
    logic               dir_zero;
    logic               org_inside;
    logic [NUM_W-1:0]   dvd_lo;
    logic [NUM_W-1:0]   dvd_hi;
    logic [REM_W-1:0]   rem_sh;
    logic               rem_ge;
    logic [REM_W-1:0]   rem_nx;
    logic [NUM_W-1:0]   quo_nx;
    logic [31:0]        q_ext;
    logic               res_neg;
    logic signed [31:0] t_div_res;
    logic               div_last;
    logic signed [31:0] m0;
    logic signed [31:0] m1;
    logic signed [31:0] t_near_nx;
    logic signed [31:0] t_far_nx;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    // Select the operands of the axis being processed.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path through the case leaves it unassigned (which would infer a latch).
        cur_dir = dir_q[0];
        cur_org = org_q[0];
        cur_min = bmin_q[0];
        cur_max = bmax_q[0];
        case (axis)
            2'd1: begin
                cur_dir = dir_q[1];
                cur_org = org_q[1];
                cur_min = bmin_q[1];
                cur_max = bmax_q[1];
            end
            2'd2: begin
                cur_dir = dir_q[2];
                cur_org = org_q[2];
                cur_min = bmin_q[2];
                cur_max = bmax_q[2];
            end
            default: ;
        endcase
    end

    // Slab offsets, magnitudes and one restoring-division step.
    always_comb begin
        cur_lo     = {1'b0, cur_min} - {1'b0, cur_org};
        cur_hi     = {1'b0, cur_max} - {1'b0, cur_org};
        lo_mag     = cur_lo[11] ? 12'd0 - cur_lo : cur_lo;
        hi_mag     = cur_hi[11] ? 12'd0 - cur_hi : cur_hi;
        dir_neg    = cur_dir[31];
        // 33 bits so that a direction of -2^31 keeps its full magnitude.
        dir_mag    = dir_neg ? 33'd0 - {1'b1, cur_dir} : {1'b0, cur_dir};
        dir_zero   = (cur_dir == 32'd0);
        org_inside = (cur_org >= cur_min) && (cur_org <= cur_max);
        dvd_lo     = {lo_mag, {FRAC_BITS{1'b0}}};
        dvd_hi     = {hi_mag, {FRAC_BITS{1'b0}}};

        rem_sh     = (rem << 1) | {{(REM_W-1){1'b0}}, dvd_sh[NUM_W-1]};
        rem_ge     = (rem_sh >= {1'b0, dir_mag});
        rem_nx     = rem_ge ? rem_sh - {1'b0, dir_mag} : rem_sh;
        quo_nx     = (quo << 1) | {{(NUM_W-1){1'b0}}, rem_ge};
        div_last   = (cnt == CNT_W'(NUM_W - 1));

        // Magnitude division truncates toward zero; the sign is applied after.
        q_ext      = {{(32-NUM_W){1'b0}}, quo_nx};
        res_neg    = ((state == S_DIV_LO) ? cur_lo[11] : cur_hi[11]) ^ dir_neg;
        t_div_res  = res_neg ? -$signed(q_ext) : $signed(q_ext);
    end

    // Order the axis slab distances and intersect them with the running interval.
    always_comb begin
        m0        = (t0 > t1) ? t1 : t0;
        m1        = (t0 > t1) ? t0 : t1;
        t_near_nx = (m0 > t_near) ? m0 : t_near;
        t_far_nx  = (m1 < t_far) ? m1 : t_far;
    end

    // Control FSM, divider and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            axis           <= 2'd0;
            miss           <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_hit        <= 1'b0;
            out_t_near     <= 32'd0;
            out_t_far      <= 32'd0;
            out_loop_index <= 32'd0;
        end else begin
            // NOTE: the ray/box copies and divider registers are not reset; they
            // are always loaded before they are read, so reset only the control
            // state and the visible outputs.
            case (state)
                S_IDLE: begin
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (in_valid) begin
                        dir_q[0]   <= in_dir_x;
                        dir_q[1]   <= in_dir_y;
                        dir_q[2]   <= in_dir_z;
                        org_q[0]   <= in_org_x;
                        org_q[1]   <= in_org_y;
                        org_q[2]   <= in_org_z;
                        bmin_q[0]  <= box_min_x;
                        bmin_q[1]  <= box_min_y;
                        bmin_q[2]  <= box_min_z;
                        bmax_q[0]  <= box_max_x;
                        bmax_q[1]  <= box_max_y;
                        bmax_q[2]  <= box_max_z;
                        idx_q      <= in_loop_index;
                        t_near     <= T_NEG;
                        t_far      <= T_POS;
                        miss       <= 1'b0;
                        axis       <= 2'd0;
                        in_ready_q <= 1'b0;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (dir_zero) begin
                        // A ray parallel to the slab hits it everywhere or nowhere.
                        if (!org_inside) begin
                            miss <= 1'b1;
                        end
                        t0    <= T_NEG;
                        t1    <= T_POS;
                        state <= S_MERGE;
                    end else begin
                        dvd_sh <= dvd_lo;
                        rem    <= '0;
                        quo    <= '0;
                        cnt    <= '0;
                        state  <= S_DIV_LO;
                    end
                end
                S_DIV_LO, S_DIV_HI: begin
                    if (div_last) begin
                        dvd_sh <= dvd_hi;
                        rem    <= '0;
                        quo    <= '0;
                        cnt    <= '0;
                        if (state == S_DIV_LO) begin
                            t0    <= t_div_res;
                            state <= S_DIV_HI;
                        end else begin
                            t1    <= t_div_res;
                            state <= S_MERGE;
                        end
                    end else begin
                        dvd_sh <= dvd_sh << 1;
                        rem    <= rem_nx;
                        quo    <= quo_nx;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                S_MERGE: begin
                    t_near <= t_near_nx;
                    t_far  <= t_far_nx;
                    if (axis == 2'd2) begin
                        state <= S_FINAL;
                    end else begin
                        axis  <= axis + 2'd1;
                        state <= S_SETUP;
                    end
                end
                S_FINAL: begin
                    out_hit        <= !miss && (t_near <= t_far) && !t_far[31];
                    out_t_near     <= t_near[31] ? 32'd0 : t_near;
                    out_t_far      <= t_far;
                    out_loop_index <= idx_q;
                    out_valid_q    <= 1'b1;
                    state          <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_box_intersector.sv
// tb_ray_box_intersector
// Directed and random rays against the slab-test block; expected results come
// from an integer reference model and are queued at drive time.
module tb_ray_box_intersector;

    typedef struct {
        logic [31:0] hit;
        logic [31:0] tn;
        logic [31:0] tf;
        logic [31:0] idx;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dir_x, in_dir_y, in_dir_z;
    logic [10:0] in_org_x, in_org_y, in_org_z;
    logic [31:0] in_loop_index;
    logic [10:0] box_min_x, box_min_y, box_min_z;
    logic [10:0] box_max_x, box_max_y, box_max_z;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [31:0] out_t_near;
    logic [31:0] out_t_far;
    logic [31:0] out_loop_index;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ray_box_intersector #(.FRAC_BITS(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dir_x(in_dir_x), .in_dir_y(in_dir_y), .in_dir_z(in_dir_z),
        .in_org_x(in_org_x), .in_org_y(in_org_y), .in_org_z(in_org_z),
        .in_loop_index(in_loop_index),
        .box_min_x(box_min_x), .box_min_y(box_min_y), .box_min_z(box_min_z),
        .box_max_x(box_max_x), .box_max_y(box_max_y), .box_max_z(box_max_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_t_near(out_t_near), .out_t_far(out_t_far),
        .out_loop_index(out_loop_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference slab test in wide integer arithmetic.
    function automatic exp_t model(input logic [31:0] d [3], input logic [10:0] o [3],
                                   input logic [10:0] mn [3], input logic [10:0] mx [3],
                                   input logic [31:0] idx);
        exp_t   e;
        longint tn = -64'sd2147483648;
        longint tf = 64'sd2147483647;
        longint t0, t1, tmp, dv;
        bit     miss = 0;
        int     zeros = 0;
        for (int a = 0; a < 3; a++) begin
            dv = longint'($signed(d[a]));
            if (dv == 0) begin
                zeros++;
                if (!(mn[a] <= o[a] && o[a] <= mx[a])) miss = 1;
                t0 = -64'sd2147483648;
                t1 = 64'sd2147483647;
            end else begin
                t0 = ((longint'(mn[a]) - longint'(o[a])) * 65536) / dv;
                t1 = ((longint'(mx[a]) - longint'(o[a])) * 65536) / dv;
            end
            if (t0 > t1) begin tmp = t0; t0 = t1; t1 = tmp; end
            if (t0 > tn) tn = t0;
            if (t1 < tf) tf = t1;
        end
        e.hit = {31'd0, (!miss && tn <= tf && tf >= 0)};
        e.tn  = (tn < 0) ? 32'd0 : tn[31:0];
        e.tf  = tf[31:0];
        e.idx = idx;
        e.lat = 175 - 56 * zeros;
        return e;
    endfunction

    task automatic set_box(input logic [10:0] nx, ny, nz, xx, xy, xz);
        box_min_x = nx; box_min_y = ny; box_min_z = nz;
        box_max_x = xx; box_max_y = xy; box_max_z = xz;
    endtask

    // Drive one ray, queue its expected result, return just after the accept edge.
    task automatic send_ray(input logic [31:0] dx, dy, dz,
                            input logic [10:0] ox, oy, oz, input logic [31:0] idx);
        logic [31:0] d [3];
        logic [10:0] o [3];
        logic [10:0] mn [3];
        logic [10:0] mx [3];
        int n = 0;
        d  = '{dx, dy, dz};
        o  = '{ox, oy, oz};
        mn = '{box_min_x, box_min_y, box_min_z};
        mx = '{box_max_x, box_max_y, box_max_z};
        in_dir_x = dx; in_dir_y = dy; in_dir_z = dz;
        in_org_x = ox; in_org_y = oy; in_org_z = oz;
        in_loop_index = idx;
        in_valid = 1'b1;
        sb.push_back(model(d, o, mn, mx, idx));
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result, compare it, optionally stall, then complete the handshake.
    task automatic recv(input int bp);
        exp_t e;
        int   cyc = 0;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1; cyc++;
        end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("latency", 32'(cyc), 32'(e.lat));
            check("hit", {31'd0, out_hit}, e.hit);
            check("t_near", out_t_near, e.tn);
            check("t_far", out_t_far, e.tf);
            check("loop_index", out_loop_index, e.idx);
            if (bp > 0) begin
                repeat (bp) begin @(posedge clk); #1; end
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_hit", {31'd0, out_hit}, e.hit);
                check("bp_t_near", out_t_near, e.tn);
                check("bp_t_far", out_t_far, e.tf);
                check("bp_loop_index", out_loop_index, e.idx);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("post_out_valid", {31'd0, out_valid}, 32'd0);
            check("post_in_ready", {31'd0, in_ready}, 32'd1);
            check("post_t_far_held", out_t_far, e.tf);
        end
    endtask

    initial begin
        logic [31:0] rd [3];
        logic [10:0] ro [3];
        logic [10:0] rmn [3];
        logic [10:0] rmx [3];
        int r;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_dir_x = '0; in_dir_y = '0; in_dir_z = '0;
        in_org_x = '0; in_org_y = '0; in_org_z = '0;
        in_loop_index = '0;
        set_box(11'd10, 11'd10, 11'd10, 11'd20, 11'd20, 11'd20);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_hit", {31'd0, out_hit}, 32'd0);
        check("rst_t_near", out_t_near, 32'd0);
        check("rst_t_far", out_t_far, 32'd0);
        check("rst_loop_index", out_loop_index, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases against box (10..20)^3.
        send_ray(32'd1, 32'd1, 32'd1, 11'd0, 11'd0, 11'd0, 32'hCAFE_0001);
        recv(0);
        send_ray(32'd2, 32'd0, 32'd0, 11'd0, 11'd15, 11'd15, 32'h0000_0002);
        recv(0);
        send_ray(32'd0, 32'd1, 32'd0, 11'd0, 11'd0, 11'd0, 32'h0000_0003);
        recv(0);
        send_ray(32'd1, 32'd0, 32'd0, 11'd15, 11'd15, 11'd15, 32'h0000_0004);
        recv(0);
        send_ray(32'd1, 32'd0, 32'd0, 11'd30, 11'd15, 11'd15, 32'h0000_0005);
        recv(0);
        send_ray(32'hFFFF_FFFF, 32'd0, 32'd0, 11'd30, 11'd15, 11'd15, 32'h0000_0006);
        recv(0);
        send_ray(32'h8000_0000, 32'd3, 32'hFFFF_FFFD, 11'd0, 11'd2047, 11'd5, 32'h0000_0007);
        recv(0);

        // Backpressure: result held for 20 cycles.
        send_ray(32'd1, 32'd1, 32'd1, 11'd0, 11'd0, 11'd0, 32'h0000_0008);
        recv(20);

        // Reset during DIV_HI of the x axis drops the ray and clears outputs.
        send_ray(32'd3, 32'd5, 32'd7, 11'd0, 11'd0, 11'd0, 32'h0000_0009);
        repeat (40) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_hit", {31'd0, out_hit}, 32'd0);
        check("midrst_t_near", out_t_near, 32'd0);
        check("midrst_t_far", out_t_far, 32'd0);
        check("midrst_loop_index", out_loop_index, 32'd0);
        @(posedge clk); #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        send_ray(32'd1, 32'd1, 32'd1, 11'd0, 11'd0, 11'd0, 32'h0000_000A);
        recv(0);

        // Back-to-back random rays with random boxes.
        for (int k = 0; k < 100; k++) begin
            for (int a = 0; a < 3; a++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      rd[a] = 32'd0;
                else if (r == 1) rd[a] = 32'h8000_0000;
                else if (r < 6)  rd[a] = 32'($urandom_range(0, 200)) - 32'd100;
                else             rd[a] = $urandom;
                rmn[a] = 11'($urandom_range(0, 2047));
                rmx[a] = 11'($urandom_range(int'(rmn[a]), 2047));
                ro[a]  = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(int'(rmn[a]), int'(rmx[a])))
                                                     : 11'($urandom_range(0, 2047));
            end
            set_box(rmn[0], rmn[1], rmn[2], rmx[0], rmx[1], rmx[2]);
            send_ray(rd[0], rd[1], rd[2], ro[0], ro[1], ro[2], $urandom);
            recv(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
